// File: rtl/codec_spi_responder_pkg.sv
// Shared definitions for the SPI responder: FSM state encoding and default sizing.
package codec_spi_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

  localparam int FRAME_BITS_DEF  = 16;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/codec_spi_responder_spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI pin with rise/fall detection
// performed on the synchronized value.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/codec_spi_responder.sv
// Mode-0 SPI responder with a one-word tx holding register and rx word output.
// Optional loopback (tx reloads from last rx word) under CODEC_SPI_LOOPBACK_EN.
module codec_spi_responder
  import codec_spi_responder_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oeb,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  underrun,
  output logic                  frame_err
`ifdef CODEC_SPI_LOOPBACK_EN
  ,
  input  logic                  loopback_i
`endif
);

  localparam int              CW         = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0]   LAST_BIT   = CW'(FRAME_BITS - 1);
  localparam int              SW         = $clog2(SYNC_STAGES + 2);
  localparam logic [SW-1:0]   SETTLE_MAX = SW'(SYNC_STAGES + 1);

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_mosi_s, w_lb, w_settled, w_start;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .i_clk(wb_clk_i), .i_rst_n(wb_rst_ni), .i_d(sclk),
    .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .i_clk(wb_clk_i), .i_rst_n(wb_rst_ni), .i_d(cs_n),
    .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SW-1:0]          r_settle;
  spi_state_e             r_state;
  logic [FRAME_BITS-1:0]  r_tx_hold, r_tx_shift, r_rx_shift, r_rx_data;
  logic                   r_hold_full;
  logic [CW-1:0]          r_bit_cnt;
  logic                   r_miso, r_miso_oeb, r_rx_valid, r_underrun, r_frame_err;

`ifdef CODEC_SPI_LOOPBACK_EN
  assign w_lb = loopback_i;
`else
  assign w_lb = 1'b0;
`endif

  // The cs_n preset is 1, so a cs_n held low across reset release would look like
  // a fresh falling edge; starts are ignored until the synchronizer has flushed.
  assign w_settled = (r_settle == SETTLE_MAX);
  assign w_start   = (r_state == ST_IDLE) && w_cs_fall && w_settled;
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_mosi_sync <= '0;
      r_settle    <= '0;
      r_state     <= ST_IDLE;
      r_tx_hold   <= '0;
      r_hold_full <= 1'b0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_bit_cnt   <= '0;
      r_miso      <= 1'b0;
      r_miso_oeb  <= 1'b1;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_mosi_sync[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) r_mosi_sync[i] <= r_mosi_sync[i-1];
      if (!w_settled) r_settle <= r_settle + 1'b1;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;

      // A start with a full buffer consumes it; otherwise an offered word is
      // accepted even in the start cycle and kept for the following frame.
      if (w_start && r_hold_full && !w_lb) begin
        r_hold_full <= 1'b0;
      end else if (tx_valid && !r_hold_full) begin
        r_tx_hold   <= tx_data;
        r_hold_full <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state    <= ST_SHIFT;
            r_bit_cnt  <= '0;
            r_miso_oeb <= 1'b0;
            if (w_lb) begin
              r_tx_shift <= r_rx_data;
              r_miso     <= r_rx_data[FRAME_BITS-1];
            end else if (r_hold_full) begin
              r_tx_shift <= r_tx_hold;
              r_miso     <= r_tx_hold[FRAME_BITS-1];
            end else begin
              r_tx_shift <= '0;
              r_miso     <= 1'b0;
              r_underrun <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (w_cs_rise) begin
            r_state     <= ST_IDLE;
            r_frame_err <= 1'b1;
            r_miso      <= 1'b0;
            r_miso_oeb  <= 1'b1;
          end else if (w_sclk_rise) begin
            r_rx_shift <= {r_rx_shift[FRAME_BITS-2:0], w_mosi_s};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == LAST_BIT) begin
              r_state    <= ST_DONE;
              r_rx_data  <= {r_rx_shift[FRAME_BITS-2:0], w_mosi_s};
              r_rx_valid <= 1'b1;
              r_miso     <= 1'b0;
            end
          end else if (w_sclk_fall) begin
            r_tx_shift <= {r_tx_shift[FRAME_BITS-2:0], 1'b0};
            r_miso     <= r_tx_shift[FRAME_BITS-2];
          end
        end
        ST_DONE: begin
          if (w_cs_rise) begin
            r_state    <= ST_IDLE;
            r_miso_oeb <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign miso      = r_miso;
  assign miso_oeb  = r_miso_oeb;
  assign tx_ready  = ~r_hold_full;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign underrun  = r_underrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_codec_spi_responder.sv
// Directed bench for codec_spi_responder acting as the SPI initiator at ratio 8,
// with a queue-based scoreboard for received and transmitted words.
module tb_codec_spi_responder;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oeb, tx_ready, rx_valid, underrun, frame_err;
  logic [15:0] tx_data = 16'h0;
  logic        tx_valid = 1'b0;
  logic [15:0] rx_data;
`ifdef CODEC_SPI_LOOPBACK_EN
  logic        loopback_i = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int n_rxv = 0, n_udr = 0, n_ferr = 0;
  bit prev_rxv = 0, prev_udr = 0, prev_ferr = 0;
  logic [15:0] exp_rx_q[$];
  logic [15:0] exp_tx_q[$];

  always #5 wb_clk_i = ~wb_clk_i;

  codec_spi_responder dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oeb (miso_oeb),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .underrun (underrun),
    .frame_err(frame_err)
`ifdef CODEC_SPI_LOOPBACK_EN
    ,
    .loopback_i(loopback_i)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic load_tx(input logic [15:0] w);
    tx_data  = w;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] mosi_w, input int nbits, input bit end_cs,
                           input bit simul, input logic [15:0] simul_w,
                           output logic [15:0] miso_w);
    miso_w = '0;
    cs_n   = 1'b0;
    if (simul) begin
      repeat (2) tick();
      tx_data  = simul_w;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
    end
    for (int i = 0; i < nbits; i++) begin
      mosi = mosi_w[15-i];
      repeat (4) tick();
      miso_w[15-i] = miso;
      if (i == 0) check("oeb_active", 32'(miso_oeb), 32'd0);
      sclk = 1'b1;
      repeat (4) tick();
      sclk = 1'b0;
    end
    if (end_cs) begin
      if (nbits == 16) begin
        repeat (4) tick();
        check("miso_done_zero", 32'(miso), 32'd0);
        check("oeb_done", 32'(miso_oeb), 32'd0);
      end
      cs_n = 1'b1;
      repeat (6) tick();
      check("oeb_idle", 32'(miso_oeb), 32'd1);
      check("miso_idle", 32'(miso), 32'd0);
    end
  endtask

  always @(negedge wb_clk_i) begin
    if (rx_valid) begin
      n_rxv++;
      check("rxv_width", 32'(prev_rxv), 32'd0);
      if (exp_rx_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
      else check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
    end
    if (underrun) begin
      n_udr++;
      check("udr_width", 32'(prev_udr), 32'd0);
    end
    if (frame_err) begin
      n_ferr++;
      check("ferr_width", 32'(prev_ferr), 32'd0);
    end
    prev_rxv  = rx_valid;
    prev_udr  = underrun;
    prev_ferr = frame_err;
  end

  initial begin
    logic [15:0] got;
    int u0, r0, f0;

    // Reset state
    repeat (3) tick();
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_oeb", 32'(miso_oeb), 32'd1);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_pulses", {29'd0, rx_valid, underrun, frame_err}, 32'd0);
    wb_rst_ni = 1'b1;
    repeat (6) tick();

    // Basic frame
    load_tx(16'hA5C3);
    check("loaded_not_ready", 32'(tx_ready), 32'd0);
    exp_rx_q.push_back(16'h1234);
    exp_tx_q.push_back(16'hA5C3);
    run_frame(16'h1234, 16, 1'b1, 1'b0, 16'h0, got);
    check("basic_miso", 32'(got), 32'(exp_tx_q.pop_front()));
    check("basic_rxv_cnt", 32'(n_rxv), 32'd1);
    check("basic_no_udr", 32'(n_udr), 32'd0);
    check("basic_rx_data", 32'(rx_data), 32'h1234);
    check("basic_ready", 32'(tx_ready), 32'd1);

    // Underrun
    exp_rx_q.push_back(16'h5A5A);
    exp_tx_q.push_back(16'h0000);
    run_frame(16'h5A5A, 16, 1'b1, 1'b0, 16'h0, got);
    check("udr_miso", 32'(got), 32'(exp_tx_q.pop_front()));
    check("udr_cnt", 32'(n_udr), 32'd1);
    check("udr_rxv_cnt", 32'(n_rxv), 32'd2);

    // Abort after 7 bits
    load_tx(16'h1111);
    run_frame(16'hFFFF, 7, 1'b1, 1'b0, 16'h0, got);
    check("abort_ferr_cnt", 32'(n_ferr), 32'd1);
    check("abort_rxv_cnt", 32'(n_rxv), 32'd2);
    check("abort_rx_kept", 32'(rx_data), 32'h5A5A);
    check("abort_ready", 32'(tx_ready), 32'd1);

    // Simultaneous load in the start cycle with empty buffer
    exp_rx_q.push_back(16'h0F0F);
    exp_tx_q.push_back(16'h0000);
    run_frame(16'h0F0F, 16, 1'b1, 1'b1, 16'h00FF, got);
    check("simul_miso", 32'(got), 32'(exp_tx_q.pop_front()));
    check("simul_udr_cnt", 32'(n_udr), 32'd2);
    check("simul_kept", 32'(tx_ready), 32'd0);
    exp_rx_q.push_back(16'h8001);
    exp_tx_q.push_back(16'h00FF);
    run_frame(16'h8001, 16, 1'b1, 1'b0, 16'h0, got);
    check("simul_next_miso", 32'(got), 32'(exp_tx_q.pop_front()));
    check("simul_next_udr", 32'(n_udr), 32'd2);

    // Reset during SHIFT with cs_n held low across release
    load_tx(16'h7777);
    run_frame(16'hAAAA, 5, 1'b0, 1'b0, 16'h0, got);
    wb_rst_ni = 1'b0;
    repeat (3) tick();
    check("midrst_ready", 32'(tx_ready), 32'd1);
    check("midrst_oeb", 32'(miso_oeb), 32'd1);
    u0 = n_udr; r0 = n_rxv; f0 = n_ferr;
    wb_rst_ni = 1'b1;
    repeat (12) tick();
    check("postrst_oeb", 32'(miso_oeb), 32'd1);
    check("postrst_ready", 32'(tx_ready), 32'd1);
    check("postrst_rx_data", 32'(rx_data), 32'd0);
    check("postrst_pulses", 32'((n_udr - u0) + (n_rxv - r0) + (n_ferr - f0)), 32'd0);
    cs_n = 1'b1;
    repeat (6) tick();
    load_tx(16'h3C3C);
    exp_rx_q.push_back(16'hC3C3);
    exp_tx_q.push_back(16'h3C3C);
    run_frame(16'hC3C3, 16, 1'b1, 1'b0, 16'h0, got);
    check("postrst_miso", 32'(got), 32'(exp_tx_q.pop_front()));
    check("postrst_rxv", 32'(n_rxv - r0), 32'd1);
    check("postrst_udr", 32'(n_udr - u0), 32'd0);

`ifdef CODEC_SPI_LOOPBACK_EN
    // Loopback: each frame transmits the previously received word
    loopback_i = 1'b1;
    u0 = n_udr;
    exp_rx_q.push_back(16'hBEEF);
    exp_tx_q.push_back(16'hC3C3);
    run_frame(16'hBEEF, 16, 1'b1, 1'b0, 16'h0, got);
    check("lb1_miso", 32'(got), 32'(exp_tx_q.pop_front()));
    exp_rx_q.push_back(16'h0001);
    exp_tx_q.push_back(16'hBEEF);
    run_frame(16'h0001, 16, 1'b1, 1'b0, 16'h0, got);
    check("lb2_miso", 32'(got), 32'(exp_tx_q.pop_front()));
    check("lb_no_udr", 32'(n_udr - u0), 32'd0);
    check("lb_hold_untouched", 32'(tx_ready), 32'd1);
    loopback_i = 1'b0;
`endif

    repeat (4) tick();
    check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/codec_spi_responder.md
CODEC_SPI_RESPONDER -- requirements
Module: codec_spi_responder

Interface
REQ-001 Parameter FRAME_BITS, default 16: bits per SPI frame, which is also the width of the tx and rx words.
REQ-002 Parameter SYNC_STAGES, default 2: number of flip-flops in each synchronizer for sclk, cs_n and mosi.
REQ-003 Port wb_clk_i  in  1  system clock; every flop in the block runs on this clock.
REQ-004 Port wb_rst_ni  in  1  asynchronous, active-low reset.
REQ-005 Port sclk  in  1  SPI clock from the initiator (mode 0: CPOL=0, CPHA=0).
REQ-006 Port cs_n  in  1  SPI chip select, active-low.
REQ-007 Port mosi  in  1  serial data from the initiator, MSB first.
REQ-008 Port miso  out  1  serial data to the initiator, MSB first.
REQ-009 Port miso_oeb  out  1  pad output-enable, active-low; 0 only while a frame is active.
REQ-010 Port tx_data  in  FRAME_BITS  next sample to transmit to the initiator.
REQ-011 Port tx_valid / tx_ready  in / out  1 each  load handshake for the tx holding register.
REQ-012 Port rx_data  out  FRAME_BITS  last complete word received from the initiator.
REQ-013 Port rx_valid  out  1  one-cycle pulse marking a new rx_data word.
REQ-014 Port underrun  out  1  one-cycle pulse when a frame starts with the tx holding register empty.
REQ-015 Port frame_err  out  1  one-cycle pulse when cs_n deasserts mid-frame.

Function
REQ-016 Synchronization: sclk, cs_n and mosi pass through SYNC_STAGES synchronizers; edges are detected on the synchronized values.
REQ-017 Clock ratio: the initiator's sclk period is at least 8 wb_clk_i cycles; behaviour below that ratio is undefined.
REQ-018 State machine has three states: IDLE, SHIFT, DONE.
REQ-019 IDLE->SHIFT on a synchronized cs_n falling edge.
  - tx holding register full: its content moves to the tx shift register and the holding register empties.
  - tx holding register empty: the shift register loads zero and underrun pulses.
  - The bit counter clears.
REQ-020 SHIFT, synchronized sclk rising edge: sample mosi into the rx shift register and increment the bit counter.
REQ-021 SHIFT, synchronized sclk falling edge: shift the tx register so the next bit appears on miso.
  - miso shows the MSB from the cycle after IDLE->SHIFT.
REQ-022 SHIFT->DONE on the rising edge that completes bit FRAME_BITS.
  - The next cycle: rx_data updates and rx_valid pulses for one cycle.
REQ-023 DONE->IDLE on the synchronized cs_n rising edge.
  - Further sclk edges in DONE are ignored and miso holds 0.
REQ-024 Mid-frame abort: cs_n rises while in SHIFT.
  - SHIFT->IDLE, frame_err pulses, rx_data is unchanged, no rx_valid.
  - A word loaded for that frame is discarded, not reused.
REQ-025 Tx handshake:
  - tx_ready = holding register empty.
  - A load occurs when tx_valid && tx_ready.
  - If the holding register is empty at frame start, a word offered in the same cycle is accepted and kept for the next frame; the current frame still underruns.
REQ-026 Idle outputs: miso_oeb=1 and miso=0 in IDLE; miso_oeb=0 in SHIFT and DONE.
REQ-027 The rx_valid, underrun and frame_err pulses are never longer than one cycle.

Reset
REQ-028 While wb_rst_ni=0, all state resets asynchronously:
  - FSM = IDLE; holding register empty, so tx_ready=1.
  - rx_data=0, miso=0, miso_oeb=1; all pulses 0.
  - Synchronizers preset to sclk=0, cs_n=1, mosi=0.
REQ-029 Reset mid-frame abandons the frame without a frame_err pulse; after release the block waits for a fresh cs_n falling edge.

Configuration
REQ-030 Macro CODEC_SPI_LOOPBACK_EN, when defined:
  - Adds input loopback_i (1 bit).
  - While loopback_i=1, each frame start loads the shift register from the last rx_data, leaves the holding register untouched and never raises underrun.
REQ-031 When CODEC_SPI_LOOPBACK_EN is undefined, loopback_i does not exist and the behaviour is exactly REQ-019..REQ-027.

Structure
REQ-032 A shared package holds:
  - the FSM state enumeration (IDLE/SHIFT/DONE);
  - default constants for FRAME_BITS and SYNC_STAGES.
REQ-033 Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall detector, instantiated for sclk and cs_n; mosi uses its synchronizer output only.

Verification
REQ-034 Basic frame: load tx_data=0xA5C3, then run a 16-bit frame with mosi=0x1234 at ratio 8 -> miso bits 0xA5C3, rx_data=0x1234, exactly one rx_valid.
REQ-035 Underrun: frame with no tx load -> underrun pulses once, miso all zeros, rx word still received.
REQ-036 Abort: cs_n rises after 7 bits -> frame_err pulses once, no rx_valid, rx_data keeps its prior value, tx_ready=1.
REQ-037 Simultaneous load: tx_valid with 0x00FF in the cycle cs_n falls, buffer empty -> underrun this frame; next frame transmits 0x00FF.
REQ-038 Reset during SHIFT: after release, tx_ready=1, miso_oeb=1, no pulses; the next full frame succeeds.
REQ-039 With CODEC_SPI_LOOPBACK_EN and loopback_i=1: frame 1 receives 0xBEEF -> frame 2 transmits 0xBEEF, no underrun.
